// File: rtl/mario_anim_pkg.sv
// Shared types and constants for the Mario animation controller.
// Holds the animation state enum, sprite-sheet frame indices and sheet geometry.
package mario_anim_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned FRAME_W     = 3;
  localparam int unsigned ADDR_W      = 13;
  localparam int unsigned FRAME_WORDS = 1024;

  typedef enum logic [1:0] {
    STAND = 2'd0,
    RUN   = 2'd1,
    SKID  = 2'd2,
    JUMP  = 2'd3
  } anim_state_t;

  localparam logic [FRAME_W-1:0] FR_STAND = 3'd0;
  localparam logic [FRAME_W-1:0] FR_RUN0  = 3'd1;
  localparam logic [FRAME_W-1:0] FR_SKID  = 3'd4;
  localparam logic [FRAME_W-1:0] FR_JUMP  = 3'd5;

  // Sheet frame index shown for a given pose; RUN uses the run-cycle step 1..3.
  function automatic logic [FRAME_W-1:0] frame_of(anim_state_t s, logic [1:0] run_frame);
    logic [FRAME_W-1:0] f;
    f = FR_STAND;
    case (s)
      STAND:   f = FR_STAND;
      RUN:     f = {1'b0, run_frame};
      SKID:    f = FR_SKID;
      default: f = FR_JUMP;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mario_sprite_addr.sv
// Combinational sprite-box test and sheet address generation.
// Ports: draw_x/draw_y current pixel, pos_x/pos_y sprite top-left,
//        frame sheet frame index, is_right facing; inside_c pixel in box,
//        addr_c sheet word address (0 outside the box).
module mario_sprite_addr
  import mario_anim_pkg::*;
#(
  parameter int unsigned SPR_W = 32
) (
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [FRAME_W-1:0] frame,
  input  logic               is_right,
  output logic               inside_c,
  output logic [ADDR_W-1:0]  addr_c
);

  localparam int unsigned AW    = $clog2(SPR_W);
  localparam int unsigned SUM_W = COORD_W + 1;

  logic [AW-1:0]    dx;
  logic [AW-1:0]    dy;
  logic [AW-1:0]    col;
  logic [SUM_W-1:0] x_end;
  logic [SUM_W-1:0] y_end;

  // Box edges are widened by one bit so a sprite near the right/bottom edge never wraps.
  always_comb begin
    dx       = AW'(draw_x - pos_x);
    dy       = AW'(draw_y - pos_y);
    x_end    = SUM_W'(pos_x) + SUM_W'(SPR_W);
    y_end    = SUM_W'(pos_y) + SUM_W'(SPR_W);
    inside_c = (draw_x >= pos_x) && (SUM_W'(draw_x) < x_end) &&
               (draw_y >= pos_y) && (SUM_W'(draw_y) < y_end);
    // Facing left mirrors the column: SPR_W-1-dx is the bitwise inverse for a power-of-two width.
    col      = is_right ? dx : ~dx;
    addr_c   = inside_c ? ADDR_W'(32'(frame) * FRAME_WORDS + 32'(dy) * SPR_W + 32'(col)) : '0;
  end

endmodule

// File: rtl/mario_anim_ctrl.sv
// Mario sprite animation sequencer: picks stand/run/skid/jump frame once per
// video frame and registers the per-pixel sheet address and box-valid flag.
// Optional skid pose enabled by defining MARIO_ANIM_SKID_EN.
// Ports: vga_clk, reset_n (async active-low), frame_start (vblank pulse),
//        move_left/move_right/airborne (game inputs), mario_x/mario_y (sprite
//        top-left), DrawX/DrawY (pixel, presented one cycle ahead);
//        rom_address, sprite_valid, is_right, anim_frame (all registered).
module mario_anim_ctrl
  import mario_anim_pkg::*;
#(
  parameter int unsigned ANIM_DIV    = 6,
  parameter int unsigned SKID_FRAMES = 8,
  parameter int unsigned SPR_W       = 32
) (
  input  logic                vga_clk,
  input  logic                reset_n,
  input  logic                frame_start,
  input  logic                move_left,
  input  logic                move_right,
  input  logic                airborne,
  input  logic [COORD_W-1:0]  mario_x,
  input  logic [COORD_W-1:0]  mario_y,
  input  logic [COORD_W-1:0]  DrawX,
  input  logic [COORD_W-1:0]  DrawY,
  output logic [ADDR_W-1:0]   rom_address,
  output logic                sprite_valid,
  output logic                is_right,
  output logic [FRAME_W-1:0]  anim_frame
);

  localparam int unsigned DIV_W = $clog2(ANIM_DIV + 1);

  anim_state_t        state, state_n;
  logic [1:0]         run_frame, run_frame_n;
  logic [DIV_W-1:0]   div_cnt, div_cnt_n;
  logic               is_right_n;
  logic [FRAME_W-1:0] anim_frame_n;
  logic               dir_cmd;
  logic               inside_c;
  logic [ADDR_W-1:0]  addr_c;

`ifdef MARIO_ANIM_SKID_EN
  localparam int unsigned SKID_W = $clog2(SKID_FRAMES + 1);
  logic [SKID_W-1:0] skid_cnt, skid_cnt_n;
  logic              opposite;
`endif

  // Next-state and counter logic; nothing moves except on frame_start.
  always_comb begin
    state_n      = state;
    run_frame_n  = run_frame;
    div_cnt_n    = div_cnt;
    is_right_n   = is_right;
    anim_frame_n = anim_frame;
    dir_cmd      = move_left ^ move_right;
`ifdef MARIO_ANIM_SKID_EN
    skid_cnt_n   = skid_cnt;
    opposite     = dir_cmd && (move_right != is_right);
`endif
    if (frame_start) begin
      if (dir_cmd) is_right_n = move_right;
      case (state)
        STAND: begin
          if (airborne) state_n = JUMP;
          else if (dir_cmd) begin
            state_n     = RUN;
            run_frame_n = 2'd1;
            div_cnt_n   = '0;
          end
        end
        RUN: begin
          if (airborne) state_n = JUMP;
          else if (!dir_cmd) state_n = STAND;
`ifdef MARIO_ANIM_SKID_EN
          else if (opposite) begin
            state_n    = SKID;
            skid_cnt_n = '0;
          end
`endif
          else if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
            div_cnt_n   = '0;
            run_frame_n = (run_frame == 2'd3) ? 2'd1 : run_frame + 2'd1;
          end else begin
            div_cnt_n = div_cnt + DIV_W'(1);
          end
        end
`ifdef MARIO_ANIM_SKID_EN
        SKID: begin
          if (airborne) state_n = JUMP;
          else if (skid_cnt == SKID_W'(SKID_FRAMES - 1)) begin
            state_n     = dir_cmd ? RUN : STAND;
            run_frame_n = 2'd1;
            div_cnt_n   = '0;
          end else begin
            skid_cnt_n = skid_cnt + SKID_W'(1);
          end
        end
`endif
        JUMP: begin
          if (!airborne) begin
            state_n     = dir_cmd ? RUN : STAND;
            run_frame_n = 2'd1;
            div_cnt_n   = '0;
          end
        end
        default: state_n = STAND;
      endcase
      anim_frame_n = frame_of(state_n, run_frame_n);
    end
  end

  mario_sprite_addr #(
    .SPR_W (SPR_W)
  ) u_addr (
    .draw_x   (DrawX),
    .draw_y   (DrawY),
    .pos_x    (mario_x),
    .pos_y    (mario_y),
    .frame    (anim_frame),
    .is_right (is_right),
    .inside_c (inside_c),
    .addr_c   (addr_c)
  );

  // State, counters and output registers.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= STAND;
      run_frame    <= 2'd1;
      div_cnt      <= '0;
      is_right     <= 1'b1;
      anim_frame   <= FR_STAND;
      rom_address  <= '0;
      sprite_valid <= 1'b0;
`ifdef MARIO_ANIM_SKID_EN
      skid_cnt     <= '0;
`endif
    end else begin
      state        <= state_n;
      run_frame    <= run_frame_n;
      div_cnt      <= div_cnt_n;
      is_right     <= is_right_n;
      anim_frame   <= anim_frame_n;
      rom_address  <= addr_c;
      sprite_valid <= inside_c;
`ifdef MARIO_ANIM_SKID_EN
      skid_cnt     <= skid_cnt_n;
`endif
    end
  end

endmodule
